// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo pose sequencer.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RAMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned HOME_ANGLE_DEF = 90;
  localparam int unsigned MAX_ANGLE_DEF  = 180;

  // Joint order on the maze-drawing arm.
  localparam int unsigned BOT_EXT = 0;
  localparam int unsigned BOT_ROT = 1;
  localparam int unsigned TOP_EXT = 2;
  localparam int unsigned END_ROT = 3;

endpackage

// File: rtl/servo_slew_channel.sv
// One servo joint: current angle and snapshotted target, stepping by one degree.
module servo_slew_channel #(
  parameter int unsigned ANGLE_W    = 8,
  parameter int unsigned HOME_ANGLE = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [ANGLE_W-1:0] load_target,
  input  logic               step,
  output logic [ANGLE_W-1:0] angle,
  output logic               at_target_c
);

  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [ANGLE_W-1:0] target_q, target_d;

  assign angle       = angle_q;
  assign at_target_c = (angle_q == target_q);

  // Target capture and single-degree move toward the target.
  always_comb begin
    angle_d  = angle_q;
    target_d = target_q;
    if (load) begin
      target_d = load_target;
    end
    if (step && !at_target_c) begin
      angle_d = (angle_q < target_q) ? angle_q + ANGLE_W'(1) : angle_q - ANGLE_W'(1);
    end
  end

  // Angle and target registers, both start at home.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q  <= ANGLE_W'(HOME_ANGLE);
      target_q <= ANGLE_W'(HOME_ANGLE);
    end else begin
      angle_q  <= angle_d;
      target_q <= target_d;
    end
  end

endmodule

// File: rtl/servo_pose_sequencer.sv
// Pose table plus rate-limited multi-joint slew toward a requested pose.
module servo_pose_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ANGLE_W    = 8,
  parameter int unsigned NUM_POSES  = 16,
  parameter int unsigned POSE_W     = $clog2(NUM_POSES),
  parameter int unsigned STEP_DIV   = 50000,
  parameter int unsigned MAX_ANGLE  = MAX_ANGLE_DEF,
  parameter int unsigned HOME_ANGLE = HOME_ANGLE_DEF,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [POSE_W-1:0]         req_pose,
  input  logic                      halt,
  input  logic                      wr_en,
  input  logic [POSE_W-1:0]         wr_pose,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [ANGLE_W-1:0]        wr_angle,
  output logic [NUM_CH*ANGLE_W-1:0] angle,
  output logic                      busy,
  output logic                      done,
  output logic                      pose_err
);

  localparam int unsigned IDX_W   = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1;
  localparam int unsigned PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_e              state_q, state_d;
  logic [POSE_W-1:0]   pose_q, pose_d;
  logic                err_q, err_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pose_err_q, pose_err_d;
  logic                req_ready_q, req_ready_d;
  logic [ANGLE_W-1:0]  table_q [NUM_POSES][NUM_CH];
  logic [ANGLE_W-1:0]  table_d [NUM_POSES][NUM_CH];

  logic [NUM_CH-1:0]   at_target_c;
  logic [ANGLE_W-1:0]  lane_c   [NUM_CH];
  logic [ANGLE_W-1:0]  target_c [NUM_CH];
  logic                all_at_c, load_c, step_c;
  logic                pose_ok_c, wr_ok_c;
  logic [IDX_W-1:0]    pose_idx_c, wr_idx_c;
  logic [ANGLE_W-1:0]  wr_clamp_c;

  assign pose_ok_c  = (32'(pose_q) < NUM_POSES);
  assign wr_ok_c    = (32'(wr_pose) < NUM_POSES);
  assign pose_idx_c = pose_q[IDX_W-1:0];
  assign wr_idx_c   = wr_pose[IDX_W-1:0];
  assign wr_clamp_c = (32'(wr_angle) > MAX_ANGLE) ? ANGLE_W'(MAX_ANGLE) : wr_angle;
  assign all_at_c   = &at_target_c;

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pose_err  = pose_err_q;

  // Bad pose index degenerates to a zero-length move onto the current angles.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      target_c[ch] = pose_ok_c ? table_q[pose_idx_c][ch] : lane_c[ch];
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    servo_slew_channel #(
      .ANGLE_W    (ANGLE_W),
      .HOME_ANGLE (HOME_ANGLE)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load_c),
      .load_target (target_c[ch]),
      .step        (step_c),
      .angle       (lane_c[ch]),
      .at_target_c (at_target_c[ch])
    );
    assign angle[ch*ANGLE_W +: ANGLE_W] = lane_c[ch];
  end

  // Pose table write path with saturation; out-of-range poses are dropped.
  always_comb begin
    table_d = table_q;
    if (wr_en && wr_ok_c) begin
      table_d[wr_idx_c][wr_ch] = wr_clamp_c;
    end
  end

  // Sequencer next-state, prescaler and registered-output decode.
  always_comb begin
    state_d = state_q;
    pose_d  = pose_q;
    err_d   = err_q;
    presc_d = presc_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          pose_d  = req_pose;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        presc_d = '0;
        err_d   = !pose_ok_c;
        state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (all_at_c) begin
          state_d = ST_DONE;
        end else if (!halt) begin
          if (presc_q == PRESC_W'(STEP_DIV - 1)) begin
            presc_d = '0;
            step_c  = 1'b1;
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_RAMP);
    done_d      = (state_d == ST_DONE);
    pose_err_d  = (state_d == ST_DONE) && err_q;
    req_ready_d = (state_d == ST_IDLE);
  end

  // Control, status and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pose_q      <= '0;
      err_q       <= 1'b0;
      presc_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pose_err_q  <= 1'b0;
      req_ready_q <= 1'b1;
      for (int p = 0; p < NUM_POSES; p++) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          table_q[p][ch] <= ANGLE_W'(HOME_ANGLE);
        end
      end
    end else begin
      state_q     <= state_d;
      pose_q      <= pose_d;
      err_q       <= err_d;
      presc_q     <= presc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pose_err_q  <= pose_err_d;
      req_ready_q <= req_ready_d;
      table_q     <= table_d;
    end
  end

endmodule

// File: tb/tb_servo_pose_sequencer.sv
// Directed bench for servo_pose_sequencer with NUM_CH=4, STEP_DIV=4.
module tb_servo_pose_sequencer;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned ANGLE_W   = 8;
  localparam int unsigned NUM_POSES = 16;
  localparam int unsigned POSE_W    = 5;
  localparam int unsigned STEP_DIV  = 4;
  localparam logic [31:0] HOME4     = {4{8'd90}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        halt = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  req_pose = '0;
  logic [4:0]  wr_pose = '0;
  logic [1:0]  wr_ch = '0;
  logic [7:0]  wr_angle = '0;
  logic [31:0] angle;
  logic        req_ready, busy, done, pose_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servo_pose_sequencer #(
    .NUM_CH    (NUM_CH),
    .ANGLE_W   (ANGLE_W),
    .NUM_POSES (NUM_POSES),
    .POSE_W    (POSE_W),
    .STEP_DIV  (STEP_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pose  (req_pose),
    .halt      (halt),
    .wr_en     (wr_en),
    .wr_pose   (wr_pose),
    .wr_ch     (wr_ch),
    .wr_angle  (wr_angle),
    .angle     (angle),
    .busy      (busy),
    .done      (done),
    .pose_err  (pose_err)
  );

  typedef struct {
    bit          do_wr;
    logic [4:0]  wr_p;
    logic [31:0] wr_v;
    bit          bad_wr;
    logic [4:0]  req;
    logic [31:0] exp;
    int          lat;
    bit          err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wr_one(input logic [4:0] p, input logic [1:0] ch, input logic [7:0] a);
    wr_en = 1'b1; wr_pose = p; wr_ch = ch; wr_angle = a;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_all(input logic [4:0] p, input logic [31:0] v);
    for (int ch = 0; ch < 4; ch++) wr_one(p, 2'(ch), v[ch*8 +: 8]);
  endtask

  // Issue one request and follow it to done, checking cadence and timing.
  task automatic run_move(input logic [4:0] p, input logic [31:0] exp, input int lat,
                          input bit err, input int halt_at, input int halt_len,
                          input int mwr_at, input logic [4:0] mwr_p,
                          input logic [1:0] mwr_ch, input logic [7:0] mwr_v);
    logic [31:0] prev;
    int          lastc[4];
    int          n;
    bit          seen, slew_bad, frozen_bad, hs;
    int          d;
    prev = angle; n = 0; seen = 0; slew_bad = 0; frozen_bad = 0;
    for (int ch = 0; ch < 4; ch++) lastc[ch] = -100;
    req_valid = 1'b1; req_pose = p;
    while (!seen && n < 4000) begin
      hs = halt;
      tick(); n++;
      if (n == 1) begin
        req_valid = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_not_ready", 32'(req_ready), 32'd0);
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (angle[ch*8 +: 8] != prev[ch*8 +: 8]) begin
          d = int'(angle[ch*8 +: 8]) - int'(prev[ch*8 +: 8]);
          if (d > 1 || d < -1 || (n - lastc[ch]) < 4) slew_bad = 1;
          lastc[ch] = n;
        end
      end
      if (hs && angle != prev) frozen_bad = 1;
      prev = angle;
      if (done) seen = 1;
      else begin
        if (halt_len > 0 && n == halt_at) halt = 1'b1;
        if (halt_len > 0 && n == halt_at + halt_len) halt = 1'b0;
        if (mwr_at > 0 && n == mwr_at) begin
          wr_en = 1'b1; wr_pose = mwr_p; wr_ch = mwr_ch; wr_angle = mwr_v;
        end
        if (mwr_at > 0 && n == mwr_at + 1) wr_en = 1'b0;
      end
    end
    halt = 1'b0; wr_en = 1'b0;
    check("done_latency", seen ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
    check("final_angles", angle, exp);
    check("pose_err_with_done", 32'(pose_err), 32'(err));
    check("slew_rate", 32'(slew_bad), 32'd0);
    if (halt_len > 0) check("halt_frozen", 32'(frozen_bad), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("err_one_cycle", 32'(pose_err), 32'd0);
    check("ready_after_done", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n, first, second;
    bit rdy_bad;

    vecs[0] = '{0, 5'd0, 32'h0, 0, 5'd0,  HOME4, 3, 0};
    vecs[1] = '{1, 5'd1, {8'd120, 8'd34, 8'd60, 8'd30}, 0, 5'd1,
                {8'd120, 8'd34, 8'd60, 8'd30}, 243, 0};
    vecs[2] = '{0, 5'd0, 32'h0, 0, 5'd16, {8'd120, 8'd34, 8'd60, 8'd30}, 3, 1};
    vecs[3] = '{1, 5'd2, {8'd180, 8'd0, 8'd90, 8'd200}, 0, 5'd2,
                {8'd180, 8'd0, 8'd90, 8'd180}, 603, 0};
    vecs[4] = '{0, 5'd0, 32'h0, 0, 5'd1,  {8'd120, 8'd34, 8'd60, 8'd30}, 603, 0};
    vecs[5] = '{0, 5'd0, 32'h0, 0, 5'd0,  HOME4, 243, 0};
    vecs[6] = '{1, 5'd3, {8'd90, 8'd85, 8'd95, 8'd100}, 1, 5'd3,
                {8'd90, 8'd85, 8'd95, 8'd100}, 43, 0};
    vecs[7] = '{0, 5'd0, 32'h0, 0, 5'd31, {8'd90, 8'd85, 8'd95, 8'd100}, 3, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_angles", angle, HOME4);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pose_err", 32'(pose_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(req_ready), 32'd1);

    // Table-driven moves
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) wr_all(vecs[i].wr_p, vecs[i].wr_v);
      if (vecs[i].bad_wr) wr_all(vecs[i].req + 5'd16, {4{8'd10}});
      run_move(vecs[i].req, vecs[i].exp, vecs[i].lat, vecs[i].err, 0, 0, 0, 5'd0, 2'd0, 8'd0);
    end

    // Halt for 20 cycles mid-ramp delays done by exactly 20
    wr_all(5'd4, {8'd90, 8'd90, 8'd90, 8'd70});
    run_move(5'd4, {8'd90, 8'd90, 8'd90, 8'd70}, 143, 0, 30, 20, 0, 5'd0, 2'd0, 8'd0);

    // Request held through a move and its DONE cycle
    req_valid = 1'b1; req_pose = 5'd0;
    n = 0; first = 0; second = 0; rdy_bad = 0;
    while (second == 0 && n < 300) begin
      tick(); n++;
      if (n >= 2 && n <= 82 && req_ready) rdy_bad = 1;
      if (done) begin
        if (first == 0) first = n;
        else second = n;
      end
      if (n == 84) check("ovl_ready_idle", 32'(req_ready), 32'd1);
      if (n == 85) begin
        check("ovl_reaccept_busy", 32'(busy), 32'd1);
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("ovl_not_ready", 32'(rdy_bad), 32'd0);
    check("ovl_first_done", 32'(first), 32'd83);
    check("ovl_second_done", 32'(second), 32'd87);
    check("ovl_angles", angle, HOME4);
    tick();

    // Rewrite of the active pose only affects the next request
    wr_all(5'd5, {8'd90, 8'd90, 8'd90, 8'd110});
    run_move(5'd5, {8'd90, 8'd90, 8'd90, 8'd110}, 83, 0, 0, 0, 10, 5'd5, 2'd0, 8'd60);
    run_move(5'd5, {8'd90, 8'd90, 8'd90, 8'd60}, 203, 0, 0, 0, 0, 5'd0, 2'd0, 8'd0);

    // Reset mid-ramp aborts the move and restores the table
    req_valid = 1'b1; req_pose = 5'd1;
    tick();
    req_valid = 1'b0;
    repeat (49) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_angles", angle, HOME4);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    run_move(5'd1, HOME4, 3, 0, 0, 0, 0, 5'd0, 2'd0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
